// File: rtl/md_sched_if.sv
// md_sched_if: EX/ID-side handshake and HI/LO read bundle for the multiply/divide scheduler.
//   master : pipeline side (drives Start_EX, MDOp_EX, A_EX, B_EX, MDUse_ID; observes status/results)
//   slave  : md_sched side (drives Busy_EX, Stall_MD, HI, LO)
interface md_sched_if;
  logic        Start_EX;
  logic [2:0]  MDOp_EX;
  logic [31:0] A_EX;
  logic [31:0] B_EX;
  logic        MDUse_ID;
  logic        Busy_EX;
  logic        Stall_MD;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start_EX, MDOp_EX, A_EX, B_EX, MDUse_ID,
    input  Busy_EX, Stall_MD, HI, LO
  );

  modport slave (
    input  Start_EX, MDOp_EX, A_EX, B_EX, MDUse_ID,
    output Busy_EX, Stall_MD, HI, LO
  );
endinterface

// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler for the EX stage.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous active-high reset
//   md    : md_sched_if.slave (Start_EX, MDOp_EX, A_EX, B_EX, MDUse_ID in;
//           Busy_EX, Stall_MD, HI, LO out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation in flight; accepts mult/multu/div/divu/mthi/mtlo
// BUSY  | countdown running on latched operands; new starts ignored
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_sched_if.slave md
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  // Result datapath works on the latched operands and is only sampled at the
  // final countdown edge.
  logic [63:0] prod_s, prod_u;
  logic        div_signed, div_by_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    div_signed  = (op_q == OP_DIV);
    div_by_zero = (b_q == 32'd0);
    a_mag  = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    b_mag  = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    // Keep the divider away from a zero divisor; the result is discarded then.
    b_safe = div_by_zero ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    // Quotient truncates toward zero, remainder takes the dividend's sign.
    // 0x80000000 / -1 naturally wraps back to 0x80000000 with remainder 0.
    quot = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
    rem  = (div_signed && a_q[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (md.Start_EX) begin
          case (md.MDOp_EX)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = md.MDOp_EX;
              a_d     = md.A_EX;
              b_d     = md.B_EX;
              cnt_d   = ((md.MDOp_EX == OP_MULT) || (md.MDOp_EX == OP_MULTU)) ?
                        CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              state_d = ST_BUSY;
            end
            OP_MTHI: hi_d = md.A_EX;
            OP_MTLO: lo_d = md.A_EX;
            default: ;
          endcase
        end
      end

      default: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          case (op_q)
            OP_MULT: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
              if (!div_by_zero) begin
                hi_d = rem;
                lo_d = quot;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.Busy_EX  = (state_q == ST_BUSY);
  // Start_EX term covers the cycle before Busy_EX rises.
  assign md.Stall_MD = md.MDUse_ID & (md.Start_EX | md.Busy_EX);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  md_sched_if u_if ();

  md_sched #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (u_if)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic start, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    u_if.Start_EX = start;
    u_if.MDOp_EX  = op;
    u_if.A_EX     = a;
    u_if.B_EX     = b;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    drive(1'b1, op, a, 32'h0);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    if (op == 3'd5) m_hi = a;
    if (op == 3'd6) m_lo = a;
    chk("mt_busy", {31'd0, u_if.Busy_EX}, 32'd0);
    chk("mt_hi", u_if.HI, m_hi);
    chk("mt_lo", u_if.LO, m_lo);
  endtask

  // Runs one multi-cycle op; inj>0 drives an mtlo 0x55 start in that busy cycle.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo, input int inj);
    res_t r;
    r.hi = ehi;
    r.lo = elo;
    sb.push_back(r);
    drive(1'b1, op, a, b);
    #1;
    chk({tag, "_stall_start"}, {31'd0, u_if.Stall_MD}, {31'd0, u_if.MDUse_ID});
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    for (int c = 1; c <= n; c++) begin
      chk({tag, "_busy"}, {31'd0, u_if.Busy_EX}, 32'd1);
      chk({tag, "_hi_hold"}, u_if.HI, m_hi);
      chk({tag, "_lo_hold"}, u_if.LO, m_lo);
      chk({tag, "_stall_busy"}, {31'd0, u_if.Stall_MD}, {31'd0, u_if.MDUse_ID});
      if (c == inj) drive(1'b1, 3'd6, 32'h55, 32'h0);
      step();
      if (c == inj) drive(1'b0, 3'd0, 32'h0, 32'h0);
    end
    chk({tag, "_busy_end"}, {31'd0, u_if.Busy_EX}, 32'd0);
    chk({tag, "_stall_end"}, {31'd0, u_if.Stall_MD}, 32'd0);
    total++;
    assert (sb.size() > 0)
    else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      r = sb.pop_front();
      m_hi = r.hi;
      m_lo = r.lo;
    end
    chk({tag, "_hi"}, u_if.HI, m_hi);
    chk({tag, "_lo"}, u_if.LO, m_lo);
  endtask

  initial begin
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    u_if.MDUse_ID = 1'b0;
    reset = 1'b1;
    m_hi = 32'h0;
    m_lo = 32'h0;
    repeat (2) step();
    reset = 1'b0;
    step();

    chk("rst_busy", {31'd0, u_if.Busy_EX}, 32'd0);
    chk("rst_stall", {31'd0, u_if.Stall_MD}, 32'd0);
    chk("rst_hi", u_if.HI, 32'h0);
    chk("rst_lo", u_if.LO, 32'h0);

    // Reset in the middle of a div 100/7 discards the pending result.
    mt(3'd5, 32'h11);
    mt(3'd6, 32'h22);
    drive(1'b1, 3'd3, 32'd100, 32'd7);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      chk("rmid_busy", {31'd0, u_if.Busy_EX}, 32'd1);
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    m_hi = 32'h0;
    m_lo = 32'h0;
    chk("rmid_busy_now", {31'd0, u_if.Busy_EX}, 32'd0);
    chk("rmid_hi_now", u_if.HI, 32'h0);
    chk("rmid_lo_now", u_if.LO, 32'h0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("rmid_after_busy", {31'd0, u_if.Busy_EX}, 32'd0);
      chk("rmid_after_hi", u_if.HI, 32'h0);
      chk("rmid_after_lo", u_if.LO, 32'h0);
    end

    run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, 0);
    run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("divu",  3'd4, 32'd7,        32'd2,        10, 32'd1,        32'd3,        0);
    run_op("divov", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000, 0);

    mt(3'd5, 32'h11);
    mt(3'd6, 32'h22);
    run_op("div0",  3'd3, 32'd5,        32'd0,        10, 32'h11,       32'h22,       0);
    run_op("divu0", 3'd4, 32'd9,        32'd0,        10, 32'h11,       32'h22,       0);

    // Stall while ID needs the unit, and mtlo during busy must be ignored.
    u_if.MDUse_ID = 1'b1;
    #1;
    chk("idle_stall", {31'd0, u_if.Stall_MD}, 32'd0);
    run_op("mult_ign", 3'd1, 32'd6, 32'd7, 5, 32'h0, 32'd42, 2);
    u_if.MDUse_ID = 1'b0;

    mt(3'd6, 32'h55);

    // Ops 0 and 7 with Start_EX leave everything alone.
    drive(1'b1, 3'd0, 32'hDEAD, 32'hBEEF);
    step();
    drive(1'b1, 3'd7, 32'hDEAD, 32'hBEEF);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    chk("nop_busy", {31'd0, u_if.Busy_EX}, 32'd0);
    chk("nop_hi", u_if.HI, m_hi);
    chk("nop_lo", u_if.LO, m_lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
